// File: rtl/cvxif_pkg.sv
// Minimal CV-X-IF constants used by the mac4b result queue.
package cvxif_pkg;

  localparam int unsigned X_ID_WIDTH = 4;

endpackage : cvxif_pkg

// File: rtl/mac4b_queue_pkg.sv
// Shared types and defaults for the mac4b result queue.
package mac4b_queue_pkg;

  localparam int unsigned DefaultDepth = 4;

  // Entry id field is sized for the CV-X-IF id width; the queue's IdWidth
  // parameter must not exceed it.
  localparam int unsigned EntryIdWidth = cvxif_pkg::X_ID_WIDTH;

  typedef struct packed {
    logic [EntryIdWidth-1:0] id;
    logic [4:0]              rd;
    logic [31:0]             data;
    logic                    committed;
    logic                    killed;
  } mac4b_entry_t;

endpackage : mac4b_queue_pkg

// File: rtl/mac4b_result_queue.sv
// In-order result queue between the mac4b issue stage and the CV-X-IF
// result interface. Entries wait for their commit; committed entries leave
// from the head in push order, killed ones are dropped silently.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready_o depends only on registered state (no pop-to-push bypass);
// result_valid_o never depends on result_ready_i and, once high, holds the
// head entry stable until it is accepted or reset is applied.
module mac4b_result_queue
  import mac4b_queue_pkg::*;
#(
  parameter int unsigned Depth   = DefaultDepth,
  parameter int unsigned IdWidth = cvxif_pkg::X_ID_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  // push port from the issue stage
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [IdWidth-1:0] in_id_i,
  input  logic [4:0]         in_rd_i,
  input  logic [31:0]        in_data_i,
  // CV-X-IF commit
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  // CV-X-IF result
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [31:0]        result_data_o,
  output logic               result_we_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  mac4b_entry_t         ent_q [Depth];
  mac4b_entry_t         ent_d [Depth];
  logic [Depth-1:0]     valid_q, valid_d;
  logic [PtrW-1:0]      head_q, head_d;
  logic [PtrW-1:0]      tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;

  mac4b_entry_t            head_ent;
  logic                    head_valid;
  logic                    head_done;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    push_commit;
  logic [EntryIdWidth-1:0] commit_id_ext;
  logic [EntryIdWidth-1:0] in_id_ext;

  // Head view, handshake qualifiers and result outputs.
  always_comb begin
    head_ent       = ent_q[head_q];
    head_valid     = valid_q[head_q];
    head_done      = head_valid && head_ent.committed;
    full           = (count_q == CntW'(Depth));
    in_ready_o     = !full;
    push           = in_valid_i && !full;
    result_valid_o = head_done && !head_ent.killed;
    // Killed heads leave without a handshake; at most one pop per cycle.
    pop            = (result_valid_o && result_ready_i) ||
                     (head_done && head_ent.killed);
    result_id_o    = IdWidth'(head_ent.id);
    result_rd_o    = head_ent.rd;
    result_data_o  = head_ent.data;
    result_we_o    = 1'b1;
    commit_id_ext  = EntryIdWidth'(commit_id_i);
    in_id_ext      = EntryIdWidth'(in_id_i);
    push_commit    = commit_valid_i && (commit_id_i == in_id_i);
  end

  // Next-state: commit marking, head pop and tail push.
  always_comb begin
    ent_d   = ent_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // A commit marks the matching uncommitted entry; unknown ids fall through.
    for (int i = 0; i < Depth; i++) begin
      if (commit_valid_i && valid_q[i] && !ent_q[i].committed &&
          (ent_q[i].id == commit_id_ext)) begin
        ent_d[i].committed = 1'b1;
        ent_d[i].killed    = commit_kill_i;
      end
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end

    // The tail slot is never valid when push is allowed, so the writes above
    // cannot collide with this one.
    if (push) begin
      ent_d[tail_q].id        = in_id_ext;
      ent_d[tail_q].rd        = in_rd_i;
      ent_d[tail_q].data      = in_data_i;
      ent_d[tail_q].committed = push_commit;
      ent_d[tail_q].killed    = push_commit && commit_kill_i;
      valid_d[tail_q]         = 1'b1;
      tail_d                  = tail_q + PtrW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset clears control and flags, payload is left as is.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        ent_q[i].committed <= 1'b0;
        ent_q[i].killed    <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ent_q   <= ent_d;
    end
  end

endmodule : mac4b_result_queue

// File: tb/tb_mac4b_result_queue.sv
// Self-checking bench for mac4b_result_queue (Depth=4, IdWidth=4).
module tb_mac4b_result_queue;

  localparam int unsigned IdWidth = 4;
  localparam int unsigned EW      = IdWidth + 5 + 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic [IdWidth-1:0] in_id;
  logic [4:0]         in_rd;
  logic [31:0]        in_data;
  logic               commit_valid, commit_kill;
  logic [IdWidth-1:0] commit_id;
  logic               result_valid, result_ready, result_we;
  logic [IdWidth-1:0] result_id;
  logic [4:0]         result_rd;
  logic [31:0]        result_data;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  mac4b_result_queue #(.Depth(4), .IdWidth(IdWidth)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_id_i(in_id),
    .in_rd_i(in_rd), .in_data_i(in_data),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id),
    .commit_kill_i(commit_kill),
    .result_valid_o(result_valid), .result_ready_i(result_ready),
    .result_id_o(result_id), .result_rd_o(result_rd),
    .result_data_o(result_data), .result_we_o(result_we)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drive slot: just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rd_of(input int id);
    return 5'((id + 3) % 32);
  endfunction

  task automatic push(input int id, input logic [31:0] data,
                      input bit commit_now, input bit kill);
    in_valid     = 1'b1;
    in_id        = IdWidth'(id);
    in_rd        = rd_of(id);
    in_data      = data;
    commit_valid = commit_now;
    commit_id    = IdWidth'(id);
    commit_kill  = kill;
    if (commit_now && !kill) exp_q.push_back({IdWidth'(id), rd_of(id), data});
    @(negedge clk);
    check("push_ready", in_ready, 1);
    step();
    in_valid     = 1'b0;
    commit_valid = 1'b0;
  endtask

  // expected payloads are registered at push time in data_of
  logic [31:0] data_of [16];

  task automatic commit(input int id, input bit kill);
    commit_valid = 1'b1;
    commit_id    = IdWidth'(id);
    commit_kill  = kill;
    if (!kill) exp_q.push_back({IdWidth'(id), rd_of(id), data_of[id]});
    step();
    commit_valid = 1'b0;
  endtask

  task automatic push_rec(input int id, input bit commit_now, input bit kill);
    data_of[id] = $urandom;
    push(id, data_of[id], commit_now, kill);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0) && (n < 50)) begin
      step();
      n++;
    end
    check("drain_expected_empty", 64'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // scoreboard monitor: a transfer is sampled mid-cycle and retires at the next edge
  always @(negedge clk) begin
    if (!rst && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {60'd0, result_id}, 64'hffff);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("result_id", result_id, e[EW-1 -: IdWidth]);
        check("result_rd", result_rd, e[36:32]);
        check("result_data", result_data, e[31:0]);
        check("result_we", result_we, 1);
      end
    end
  end

  initial begin
    in_valid = 0; in_id = '0; in_rd = '0; in_data = '0;
    commit_valid = 0; commit_id = '0; commit_kill = 0;
    result_ready = 1;
    for (int i = 0; i < 16; i++) data_of[i] = 32'h0;
    do_reset();
    @(negedge clk);
    check("reset_valid", result_valid, 0);
    check("reset_ready", in_ready, 1);
    step();

    // single entry, push with same-cycle commit
    data_of[1] = 32'h10;
    push(1, 32'h10, 1, 0);
    @(negedge clk);
    check("lat1_valid", result_valid, 1);
    step();
    @(negedge clk);
    check("lat1_empty_valid", result_valid, 0);
    check("lat1_empty_ready", in_ready, 1);
    step();

    // fill without commits, then commit the head
    for (int i = 0; i < 4; i++) push_rec(i, 0, 0);
    @(negedge clk);
    check("full_ready", in_ready, 0);
    check("full_valid", result_valid, 0);
    step();
    in_valid = 1; in_id = 4'd9; in_rd = 5'd1; in_data = 32'hdeadbeef;
    @(negedge clk);
    check("full_refuse", in_ready, 0);
    step();
    in_valid = 0;
    commit(0, 0);
    @(negedge clk);
    check("head_commit_valid", result_valid, 1);
    step();
    @(negedge clk);
    check("after_pop_ready", in_ready, 1);
    step();
    commit(1, 0);
    commit(2, 0);
    commit(3, 0);
    drain();

    // killed head is dropped silently
    push_rec(4, 0, 0);
    push_rec(5, 0, 0);
    commit(4, 1);
    @(negedge clk);
    check("kill_no_output", result_valid, 0);
    commit(5, 0);
    @(negedge clk);
    check("after_kill_valid", result_valid, 1);
    drain();

    // stall: outputs hold while ready is low
    result_ready = 0;
    data_of[6] = 32'hcafe0006;
    push(6, 32'hcafe0006, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", result_valid, 1);
      check("stall_id", result_id, 6);
      check("stall_rd", result_rd, rd_of(6));
      check("stall_data", result_data, 32'hcafe0006);
      @(posedge clk);
    end
    #1 result_ready = 1;
    step();
    @(negedge clk);
    check("stall_single_pop", result_valid, 0);
    check("stall_sb_empty", 64'(exp_q.size()), 0);
    step();

    // stream across the pointer wrap
    for (int i = 0; i < 9; i++) push_rec((i * 3 + 7) % 16, 1, 0);
    drain();

    // reset mid-stall discards presented and queued entries
    result_ready = 0;
    push_rec(10, 1, 0);
    push_rec(11, 0, 0);
    push_rec(12, 0, 0);
    @(negedge clk);
    check("pre_reset_valid", result_valid, 1);
    step();
    rst = 1;
    step();
    rst = 0;
    exp_q.delete();
    @(negedge clk);
    check("post_reset_valid", result_valid, 0);
    check("post_reset_ready", in_ready, 1);
    step();
    result_ready = 1;
    for (int i = 10; i < 13; i++) begin
      commit_valid = 1; commit_id = IdWidth'(i); commit_kill = 0;
      step();
      commit_valid = 0;
      @(negedge clk);
      check("stale_commit_no_output", result_valid, 0);
      step();
    end

    // queue usable after reset
    push_rec(13, 1, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_mac4b_result_queue
